stack_exec: RTL and testbench

- Operand-stack execution stage that sits directly upstream of the 16-bit ALU.
- Holds a LIFO of 16-bit words and accepts PUSH/POP/ALU commands over a valid/ready handshake.
- For an ALU command it pops the two top entries, drives them and the 2-bit opcode to the ALU, and pushes the ALU result back.
- Captures the ALU carry into a flag register.

---
 rtl/stack_pkg.sv | 20 ++
 rtl/stack_exec_if.sv | 13 +
 rtl/stack_regfile.sv | 25 ++
 rtl/stack_exec.sv | 142 ++++++++++++++
 tb/tb_stack_exec.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared encodings for the operand-stack execution stage: command codes,
// ALU opcodes and the two-state sequencer encoding.
package stack_pkg;

  localparam logic [1:0] CMD_PUSH = 2'b00;
  localparam logic [1:0] CMD_POP  = 2'b01;
  localparam logic [1:0] CMD_ALU  = 2'b10;
  localparam logic [1:0] CMD_NOP  = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/stack_exec_if.sv
// Command channel into the stack execution stage (valid/ready handshake).
interface stack_exec_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_code;
  logic [1:0]       cmd_aluop;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, cmd_code, cmd_aluop, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_code, cmd_aluop, cmd_data, output cmd_ready);
endinterface

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port and combinational reads of the
// top and next-of-stack entries. Contents are never reset.
module stack_regfile #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    top_addr,
  input  logic [AW-1:0]    nxt_addr,
  output logic [WIDTH-1:0] top_data,
  output logic [WIDTH-1:0] nxt_data
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign top_data = mem_q[top_addr];
  assign nxt_data = mem_q[nxt_addr];
endmodule

// File: rtl/stack_exec.sv
// Operand-stack execution stage: PUSH/POP/ALU commands over valid/ready,
// ALU operands registered for one evaluation cycle, result written back as NOS.
module stack_exec
  import stack_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int DW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  stack_exec_if.slave      cmd,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] tos,
  output logic [DW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             carry_flag,
  output logic             err
);
  state_e           state_q, state_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    top_addr, nxt_addr;
  logic [WIDTH-1:0] top_data, nxt_data;
  logic             accept;

  assign top_addr = AW'(depth_q - DW'(1));
  assign nxt_addr = AW'(depth_q - DW'(2));

  stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
    .clk      (clk),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .top_addr (top_addr),
    .nxt_addr (nxt_addr),
    .top_data (top_data),
    .nxt_data (nxt_data)
  );

  assign cmd.cmd_ready = (state_q == ST_IDLE) && !reset;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    carry_d  = carry_q;
    err_d    = 1'b0;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (cmd.cmd_code)
            CMD_PUSH: begin
              if (full) begin
                err_d = 1'b1;
              end else begin
                we      = 1'b1;
                waddr   = AW'(depth_q);
                wdata   = cmd.cmd_data;
                depth_d = depth_q + DW'(1);
              end
            end
            CMD_POP: begin
              if (empty) err_d = 1'b1;
              else       depth_d = depth_q - DW'(1);
            end
            CMD_ALU: begin
              if (depth_q < DW'(2)) begin
                err_d = 1'b1;
              end else begin
                alu_a_d  = nxt_data;
                alu_b_d  = top_data;
                alu_op_d = cmd.cmd_aluop;
                state_d  = ST_EXEC;
              end
            end
            default: ;
          endcase
        end
      end
      ST_EXEC: begin
        // Result replaces NOS; the stack shrinks by one. Reset aborts the write.
        we      = !reset;
        waddr   = AW'(depth_q - DW'(2));
        wdata   = alu_result;
        depth_d = depth_q - DW'(1);
        carry_d = alu_cout;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      depth_q  <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
    end
  end

  assign tos        = (depth_q == '0) ? '0 : top_data;
  assign depth      = depth_q;
  assign empty      = (depth_q == '0);
  assign full       = (depth_q == DW'(DEPTH));
  assign carry_flag = carry_q;
  assign err        = err_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
endmodule

// File: tb/tb_stack_exec.sv
// Bench for stack_exec: queue-based stack model checked every cycle, plus
// directed sequences with hand-computed literal expectations.
module tb_stack_exec;
  import stack_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_exec_if #(.WIDTH(WIDTH)) cmd_if ();

  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result, tos;
  logic             alu_cout;
  logic [DW-1:0]    depth;
  logic             empty, full, carry_flag, err;

  stack_exec #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_if),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .tos        (tos),
    .depth      (depth),
    .empty      (empty),
    .full       (full),
    .carry_flag (carry_flag),
    .err        (err)
  );

  // The 16-bit ALU sitting downstream of the stage
  logic [WIDTH:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case (alu_op)
      OP_ADD:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
      OP_AND:  alu_sum = {1'b0, alu_a & alu_b};
      default: alu_sum = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_result = alu_sum[WIDTH-1:0];
  assign alu_cout   = alu_sum[WIDTH];

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [WIDTH-1:0] m_stk[$];
  logic             m_busy  = 1'b0;
  logic             m_carry = 1'b0;
  logic             m_err   = 1'b0;
  logic [1:0]       m_op    = '0;
  logic [WIDTH-1:0] m_a     = '0;
  logic [WIDTH-1:0] m_b     = '0;

  function automatic logic [WIDTH:0] alu_ref(input logic [1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {(a >= b), a - b};
      OP_AND:  return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  task automatic model_edge();
    logic [WIDTH:0] r;
    m_err = 1'b0;
    if (reset) begin
      m_stk.delete();
      m_busy  = 1'b0;
      m_carry = 1'b0;
      m_op    = '0;
      m_a     = '0;
      m_b     = '0;
    end else if (m_busy) begin
      r = alu_ref(m_op, m_a, m_b);
      void'(m_stk.pop_back());
      m_stk[m_stk.size()-1] = r[WIDTH-1:0];
      m_carry = r[WIDTH];
      m_busy  = 1'b0;
    end else if (cmd_if.cmd_valid) begin
      case (cmd_if.cmd_code)
        CMD_PUSH: if (m_stk.size() == DEPTH) m_err = 1'b1;
                  else m_stk.push_back(cmd_if.cmd_data);
        CMD_POP:  if (m_stk.size() == 0) m_err = 1'b1;
                  else void'(m_stk.pop_back());
        CMD_ALU:  if (m_stk.size() < 2) m_err = 1'b1;
                  else begin
                    m_b    = m_stk[m_stk.size()-1];
                    m_a    = m_stk[m_stk.size()-2];
                    m_op   = cmd_if.cmd_aluop;
                    m_busy = 1'b1;
                  end
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tos", 32'(tos), (m_stk.size() == 0) ? 32'd0 : 32'(m_stk[m_stk.size()-1]));
      chk("depth", 32'(depth), 32'(m_stk.size()));
      chk("empty", 32'(empty), 32'(m_stk.size() == 0));
      chk("full", 32'(full), 32'(m_stk.size() == DEPTH));
      chk("carry_flag", 32'(carry_flag), 32'(m_carry));
      chk("err", 32'(err), 32'(m_err));
      chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(!m_busy && !reset));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_op", 32'(alu_op), 32'(m_op));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] code, input logic [1:0] op,
                       input logic [WIDTH-1:0] d);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_code  = code;
    cmd_if.cmd_aluop = op;
    cmd_if.cmd_data  = d;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    drive(1'b1, CMD_PUSH, OP_ADD, d);
    tick();
    drive(1'b0, CMD_NOP, OP_ADD, '0);
  endtask

  task automatic alu(input logic [1:0] op);
    drive(1'b1, CMD_ALU, op, '0);
    tick();
    drive(1'b0, CMD_NOP, OP_ADD, '0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, CMD_NOP, OP_ADD, '0);
    tick();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_tos", 32'(tos), 32'd0);
    reset = 1'b0;

    // add, with the one-cycle ready drop
    push(16'h0005);
    push(16'h0003);
    drive(1'b1, CMD_ALU, OP_ADD, '0);
    tick();
    drive(1'b0, CMD_NOP, OP_ADD, '0);
    @(negedge clk);
    chk("add_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("add_ready_back", 32'(cmd_if.cmd_ready), 32'd1);
    chk("add_tos", 32'(tos), 32'h0008);
    chk("add_depth", 32'(depth), 32'd1);
    chk("add_carry", 32'(carry_flag), 32'd0);

    // subtraction order and borrow
    push(16'h0003);
    push(16'h0005);
    alu(OP_SUB);
    @(negedge clk);
    chk("sub1_tos", 32'(tos), 32'hFFFE);
    chk("sub1_carry", 32'(carry_flag), 32'd0);
    push(16'h0002);
    alu(OP_SUB);
    @(negedge clk);
    chk("sub2_tos", 32'(tos), 32'hFFFC);
    chk("sub2_carry", 32'(carry_flag), 32'd1);

    // wraparound add, and, or
    push(16'hFFFF);
    push(16'h0001);
    alu(OP_ADD);
    @(negedge clk);
    chk("wrap_tos", 32'(tos), 32'h0000);
    chk("wrap_carry", 32'(carry_flag), 32'd1);
    push(16'h0F0F);
    alu(OP_AND);
    @(negedge clk);
    chk("and_tos", 32'(tos), 32'h0000);
    push(16'h00F0);
    alu(OP_OR);
    @(negedge clk);
    chk("or_tos", 32'(tos), 32'h00F0);
    chk("or_depth", 32'(depth), 32'd3);

    // underflow
    do_reset();
    drive(1'b1, CMD_POP, OP_ADD, '0);
    tick();
    drive(1'b0, CMD_NOP, OP_ADD, '0);
    @(negedge clk);
    chk("pop_empty_err", 32'(err), 32'd1);
    chk("pop_empty_depth", 32'(depth), 32'd0);
    tick();
    @(negedge clk);
    chk("err_one_cycle", 32'(err), 32'd0);
    push(16'h0007);
    drive(1'b1, CMD_ALU, OP_ADD, '0);
    tick();
    drive(1'b0, CMD_NOP, OP_ADD, '0);
    @(negedge clk);
    chk("alu_d1_err", 32'(err), 32'd1);
    chk("alu_d1_tos", 32'(tos), 32'h0007);
    chk("alu_d1_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // overflow
    do_reset();
    for (int i = 1; i <= 8; i++) push(16'(16'h0100 + i));
    @(negedge clk);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_depth", 32'(depth), 32'd8);
    push(16'h0109);
    @(negedge clk);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_tos", 32'(tos), 32'h0108);

    // reset while the ALU result is pending
    do_reset();
    push(16'hFFFF);
    push(16'h0001);
    alu(OP_ADD);
    @(negedge clk);
    chk("pre_rst_carry", 32'(carry_flag), 32'd1);
    push(16'h0003);
    drive(1'b1, CMD_ALU, OP_ADD, '0);
    tick();
    drive(1'b0, CMD_NOP, OP_ADD, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("exec_rst_depth", 32'(depth), 32'd0);
    chk("exec_rst_carry", 32'(carry_flag), 32'd0);
    chk("exec_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // PUSH held across EXEC is taken once, on the first IDLE edge
    push(16'h0004);
    push(16'h0006);
    drive(1'b1, CMD_ALU, OP_ADD, '0);
    tick();
    drive(1'b1, CMD_PUSH, OP_ADD, 16'h0009);
    tick();
    tick();
    drive(1'b0, CMD_NOP, OP_ADD, '0);
    @(negedge clk);
    chk("hold_depth", 32'(depth), 32'd2);
    chk("hold_tos", 32'(tos), 32'h0009);
    chk("hold_err", 32'(err), 32'd0);
    alu(OP_SUB);
    @(negedge clk);
    chk("hold_sub_tos", 32'(tos), 32'h0001);
    chk("hold_sub_carry", 32'(carry_flag), 32'd1);
    tick();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
